nbcac_decoder_iter: RTL and testbench

//  Parametrised, bit-serial successor to the fixed 16-bit NBCAC decoder core.

---
 rtl/nbcac_pkg.sv | 43 ++++
 rtl/nbcac_decoder_iter_wgen.sv | 40 ++++
 rtl/nbcac_decoder_iter.sv | 115 +++++++++++
 tb/tb_nbcac_decoder_iter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nbcac_pkg.sv
// NBCAC decoder shared types and weight helpers.
// Weight functions are elaboration-time only (sizing and checks).
package nbcac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int SEED_W = 2;

  function automatic int nbcac_weight(
    input int code_w,
    input int j
  );
    int a;
    int b;
    int w;
    if (j == 1) return 1;
    if (j >= code_w - 1) return SEED_W;
    a = SEED_W;
    b = SEED_W;
    w = SEED_W;
    for (int k = code_w - 2; k >= j; k--) begin
      w = a + b;
      b = a;
      a = w;
    end
    return w;
  endfunction

  function automatic int nbcac_max_sum(
    input int code_w
  );
    int s;
    s = 0;
    for (int j = 1; j <= code_w; j++)
      s = s + nbcac_weight(code_w, j);
    return s;
  endfunction

endpackage

// File: rtl/nbcac_decoder_iter_wgen.sv
// Fibonacci-type weight generator for the bit-serial NBCAC decoder.
// Holds the last two weights and produces the current one.
module nbcac_weight_gen #(
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             seed,
  input  logic             last,
  output logic [ACC_W-1:0] weight
);

  logic [ACC_W-1:0] wa;
  logic [ACC_W-1:0] wb;

  always_comb begin
    weight = wa + wb;
    unique case (1'b1)
      last:    weight = ACC_W'(1);
      seed:    weight = ACC_W'(2);
      default: weight = wa + wb;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa <= '0;
      wb <= '0;
    end else if (load) begin
      wa <= ACC_W'(2);
      wb <= ACC_W'(2);
    end else if (step) begin
      wb <= wa;
      wa <= weight;
    end
  end

endmodule

// File: rtl/nbcac_decoder_iter.sv
// Bit-serial NBCAC decoder: one codeword bit per cycle, MSB first,
// with valid/ready handshakes, flush and an overflow flag.
module nbcac_decoder_iter
  import nbcac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CODE_W = 23,
  parameter int ACC_W  = DATA_W + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_v,
  output logic              out_ovf
);

  localparam int CNT_W = $clog2(CODE_W + 1);

  if (CODE_W < 3) begin : g_code_w_chk
    $error("nbcac_decoder_iter: CODE_W must be at least 3");
  end
  if (ACC_W <= DATA_W) begin : g_acc_w_chk
    $error("nbcac_decoder_iter: ACC_W must exceed DATA_W");
  end
  if (ACC_W < $clog2(nbcac_max_sum(CODE_W) + 1)) begin : g_acc_sum_chk
    $error("nbcac_decoder_iter: ACC_W too small for largest sum");
  end

  state_t state;
  state_t state_nx;

  logic [CODE_W-1:0] shreg;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nx;
  logic [ACC_W-1:0]  weight;
  logic [CNT_W-1:0]  cnt;

  logic accept;
  logic running;
  logic step;
  logic seed;
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (in_valid) state_nx = RUN;
        RUN:     if (last) state_nx = DONE;
        DONE:    if (out_ready) state_nx = in_valid ? RUN : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    out_valid = (state == DONE);
    running   = (state == RUN);
    accept    = in_valid & in_ready & ~flush;
    step      = running & ~flush;
  end

  // Top two positions use the 2/2 seed, position 1 is fixed at 1.
  assign seed   = cnt >= CNT_W'(CODE_W - 1);
  assign last   = cnt == CNT_W'(1);
  assign acc_nx = acc + (shreg[CODE_W-1] ? weight : '0);

  nbcac_weight_gen #(
    .ACC_W (ACC_W)
  ) u_wgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (step),
    .seed   (seed),
    .last   (last),
    .weight (weight)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      out_v   <= '0;
      out_ovf <= 1'b0;
    end else if (accept) begin
      shreg <= in_code;
      acc   <= '0;
      cnt   <= CNT_W'(CODE_W);
    end else if (step) begin
      shreg <= shreg << 1;
      acc   <= acc_nx;
      cnt   <= cnt - CNT_W'(1);
      if (last) begin
        out_v   <= acc_nx[DATA_W-1:0];
        out_ovf <= |acc_nx[ACC_W-1:DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_nbcac_decoder_iter.sv
// Self-checking bench for nbcac_decoder_iter at 23/16 and 9/5.
// Expected results come from a weighted-sum model of the codeword.
module tb_nbcac_decoder_iter;

  localparam int AD = 16;
  localparam int AC = 23;
  localparam int BD = 5;
  localparam int BC = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_flush, a_in_valid, a_in_ready;
  logic          a_out_valid, a_out_ready, a_out_ovf;
  logic [AC-1:0] a_in_code;
  logic [AD-1:0] a_out_v;

  logic          b_flush, b_in_valid, b_in_ready;
  logic          b_out_valid, b_out_ready, b_out_ovf;
  logic [BC-1:0] b_in_code;
  logic [BD-1:0] b_out_v;

  int checks = 0;
  int fails  = 0;
  int a_q[$];
  int b_q[$];
  bit b_done = 0;

  nbcac_decoder_iter #(.DATA_W(AD), .CODE_W(AC)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_code(a_in_code), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_v(a_out_v),
    .out_ovf(a_out_ovf)
  );

  nbcac_decoder_iter #(.DATA_W(BD), .CODE_W(BC)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_code(b_in_code), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_v(b_out_v),
    .out_ovf(b_out_ovf)
  );

  function automatic int model_sum(input int cw, input logic [31:0] code);
    int w [0:32];
    int s;
    s = 0;
    w[cw] = 2;
    w[cw-1] = 2;
    for (int j = cw - 2; j >= 2; j--) w[j] = w[j+1] + w[j+2];
    w[1] = 1;
    for (int j = 1; j <= cw; j++) if (code[j-1]) s += w[j];
    return s;
  endfunction

  function automatic logic [31:0] legal_code(input int cw, input int dw);
    logic [31:0] c;
    for (int t = 0; t < 1000; t++) begin
      c = $urandom & ((32'd1 << cw) - 1);
      if (t > 10) c = c & $urandom;
      if (t > 20) c = c & $urandom;
      if (model_sum(cw, c) < (1 << dw)) return c;
    end
    return 32'd0;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare processes: every cycle a result is shown it must match the
  // oldest outstanding codeword's weighted sum.
  always @(negedge clk) begin
    if (!rst_n || a_flush) begin
      a_q.delete();
    end else begin
      if (a_out_valid) begin
        if (a_q.size() == 0) begin
          check("a_unexpected_out", 1, 0);
        end else begin
          check("a_out_v", a_out_v, a_q[0] % (1 << AD));
          check("a_out_ovf", a_out_ovf, a_q[0] >= (1 << AD));
          if (a_out_ready) void'(a_q.pop_front());
        end
      end
      if (a_in_valid && a_in_ready) a_q.push_back(model_sum(AC, 32'(a_in_code)));
    end
  end

  always @(negedge clk) begin
    if (!rst_n || b_flush) begin
      b_q.delete();
    end else begin
      if (b_out_valid) begin
        if (b_q.size() == 0) begin
          check("b_unexpected_out", 1, 0);
        end else begin
          check("b_out_v", b_out_v, b_q[0] % (1 << BD));
          check("b_out_ovf", b_out_ovf, b_q[0] >= (1 << BD));
          if (b_out_ready) void'(b_q.pop_front());
        end
      end
      if (b_in_valid && b_in_ready) b_q.push_back(model_sum(BC, 32'(b_in_code)));
    end
  end

  task automatic a_send(input logic [AC-1:0] code);
    bit ok;
    ok = 0;
    a_in_code = code;
    a_in_valid = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = a_in_ready;
    end
    if (!ok) check("a_send_timeout", 0, 1);
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic b_send(input logic [BC-1:0] code);
    bit ok;
    ok = 0;
    b_in_code = code;
    b_in_valid = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = b_in_ready;
    end
    if (!ok) check("b_send_timeout", 0, 1);
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic a_wait_out(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (a_out_valid) break;
    end
    if (!a_out_valid) check("a_wait_timeout", 0, 1);
  endtask

  task automatic a_lit(input logic [AC-1:0] code, input int sum,
                       input int v, input bit ovf);
    int lat;
    check("model_pin", model_sum(AC, 32'(code)), sum);
    a_send(code);
    a_wait_out(lat);
    check("lit_latency", lat, AC + 1);
    check("lit_out_v", a_out_v, v);
    check("lit_out_ovf", a_out_ovf, ovf);
    tick();
  endtask

  initial begin
    int lat;
    a_flush = 0; a_in_valid = 0; a_in_code = '0; a_out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_code = '0; b_out_ready = 1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_v", a_out_v, 0);
    check("rst_out_ovf", a_out_ovf, 0);
    check("rst_b_in_ready", b_in_ready, 1);
    tick();

    a_lit(23'h000001, 1, 1, 0);
    a_lit(23'h000002, 35422, 35422, 0);
    a_lit(23'h000006, 57314, 57314, 0);
    a_lit(23'h600000, 4, 4, 0);
    a_lit(23'h7FFFFF, 92735, 27199, 1);
    a_lit(23'h000000, 0, 0, 0);

    // Stalled sink, then back-to-back accept on release.
    a_out_ready = 0;
    a_send(23'h000006);
    a_wait_out(lat);
    check("stall_latency", lat, AC + 1);
    repeat (10) begin
      @(negedge clk);
      check("stall_in_ready", a_in_ready, 0);
      check("stall_out_valid", a_out_valid, 1);
      check("stall_out_v", a_out_v, 57314);
    end
    tick();
    a_out_ready = 1;
    a_in_valid = 1;
    a_in_code = 23'h000002;
    @(negedge clk);
    check("b2b_in_ready", a_in_ready, 1);
    tick();
    a_in_valid = 0;
    @(negedge clk);
    check("b2b_run_out_valid", a_out_valid, 0);
    check("b2b_run_in_ready", a_in_ready, 0);
    a_wait_out(lat);
    check("b2b_latency", lat, AC);
    check("b2b_out_v", a_out_v, 35422);
    tick();

    // Flush mid-RUN.
    a_send(23'h7FFFFF);
    repeat (11) tick();
    a_flush = 1;
    tick();
    a_flush = 0;
    @(negedge clk);
    check("flush_in_ready", a_in_ready, 1);
    repeat (30) begin
      @(negedge clk);
      check("flush_no_out", a_out_valid, 0);
    end
    tick();
    a_lit(23'h000002, 35422, 35422, 0);

    // Reset mid-RUN.
    a_send(23'h7FFFFF);
    repeat (11) tick();
    rst_n = 0;
    #1;
    check("arst_out_valid", a_out_valid, 0);
    check("arst_out_v", a_out_v, 0);
    check("arst_out_ovf", a_out_ovf, 0);
    tick();
    rst_n = 1;
    @(negedge clk);
    check("arst_in_ready", a_in_ready, 1);
    repeat (30) begin
      @(negedge clk);
      check("arst_no_out", a_out_valid, 0);
    end
    tick();
    a_lit(23'h000002, 35422, 35422, 0);

    // Random legal codewords on the wide instance.
    for (int i = 0; i < 15; i++) a_send(AC'(legal_code(AC, AD)));
    for (int n = 0; n < 200 && a_q.size() != 0; n++) @(negedge clk);
    check("a_drain", a_q.size(), 0);
    tick();

    // Narrow instance: pinned sums, then random traffic with a busy sink.
    check("b_model_all", model_sum(BC, 32'h1FF), 109);
    check("b_model_d2", model_sum(BC, 32'h002), 42);
    check("b_model_d1", model_sum(BC, 32'h001), 1);
    b_send(9'h1FF);
    b_send(9'h002);
    b_send(9'h001);
    fork
      while (!b_done) begin
        tick();
        b_out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 20; i++) b_send(BC'(legal_code(BC, BD)));
    for (int n = 0; n < 400 && b_q.size() != 0; n++) @(negedge clk);
    b_done = 1;
    check("b_drain", b_q.size(), 0);
    tick();
    b_out_ready = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
